aes_byte_tx: RTL and testbench

- Platform-side transmit stage feeding the AES chip's byte input.
- Accepts one 128-bit key and one 128-bit plaintext per request and serialises them as 32 bytes on the 9-bit `aes_tx` bus: bits [7:0] are data, bit [8] is the `shi` strobe.
- Byte pacing comes from a clock divider, so the slower chip clock samples every strobe.
- Sits between the platform's vector generator and the chip's `user_data`/`shi` pins.

---
 rtl/aes_byte_tx.sv | 162 ++++++++++++++++
 tb/tb_aes_byte_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/aes_byte_tx.sv
// aes_byte_tx: serialises a 128-bit key followed by a 128-bit plaintext as
// 32 bytes on the 9-bit {shi, data} bus feeding the AES chip. Each byte is
// held for DIV = CLK_FREQ/AES_TX_FREQ platform cycles. The shi strobe is high
// for the first DIV/2 cycles of each byte period, so the slower chip clock
// can sample every strobe.
//
// Handshake: start is sampled only in IDLE. The cycle after acceptance, busy
// rises and byte 0 is already on aes_tx. done pulses for one cycle on the last
// cycle of byte 31. The next start can be accepted only after busy falls.
//
// Optional feature (macro AES_TX_GAP_EN): after the frame, aes_tx idles for
// GAP_BYTES*DIV cycles while busy stays high. This gives the chip time to
// finish encrypting before the next frame arrives.
module aes_byte_tx #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int AES_TX_FREQ = 200_000,
  parameter int GAP_BYTES   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] text,
  output logic         busy,
  output logic         done,
  output logic [8:0]   aes_tx
);

  localparam int DIV = CLK_FREQ / AES_TX_FREQ;
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(DIV - 2);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);

  // Reject divider ratios that cannot produce both a high and a low strobe phase
  if (DIV < 2) begin : g_div_check
    $error("aes_byte_tx: CLK_FREQ/AES_TX_FREQ must be >= 2");
  end
  if (GAP_BYTES < 0) begin : g_gap_check
    $error("aes_byte_tx: GAP_BYTES must be >= 0");
  end

`ifdef AES_TX_GAP_EN
  localparam int GAP_CYC = GAP_BYTES * DIV;
  localparam int GW      = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
`endif

  // Observable state, so a checker can bind to state_q directly
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e         state_q;
  logic [255:0]   sh_q;      // latched {key,text}; the current byte sits in [255:248]
  logic [4:0]     byte_q;    // index of the byte being transmitted
  logic [DW-1:0]  div_q;     // position inside the current byte period
  logic           busy_q;
  logic           done_q;
  logic [8:0]     tx_q;
`ifdef AES_TX_GAP_EN
  logic [GW-1:0]  gap_q;
`endif

  logic           div_wrap;
  logic [DW-1:0]  div_d;
  logic           shi_d;
  logic           last_byte;

  // Divider next value and the strobe level for the next cycle
  always_comb begin
    div_wrap  = (div_q == DIV_LAST);
    div_d     = div_wrap ? '0 : div_q + DW'(1);
    shi_d     = (div_d < DIV_HALF);
    last_byte = (byte_q == 5'd31);
  end

  // Transmit FSM; every output is computed one cycle ahead and registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      byte_q  <= '0;
      div_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= '0;
`ifdef AES_TX_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q   <= '0;
          busy_q <= 1'b0;
          if (start) begin
            sh_q    <= {key, text};
            byte_q  <= '0;
            div_q   <= '0;
            tx_q    <= {1'b1, key[127:120]};
            busy_q  <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          div_q <= div_d;
          if (div_wrap) begin
            sh_q   <= {sh_q[247:0], 8'h00};
            byte_q <= byte_q + 5'd1;
            if (last_byte) begin
              tx_q <= '0;
`ifdef AES_TX_GAP_EN
              gap_q <= '0;
              if (GAP_CYC == 0) begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_GAP;
              end
`else
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
`endif
            end else begin
              tx_q <= {shi_d, sh_q[247:240]};
            end
          end else begin
            tx_q <= {shi_d, sh_q[255:248]};
            // done lands on the final cycle of byte 31
            if (last_byte && (div_q == DIV_PRE)) begin
              done_q <= 1'b1;
            end
          end
        end
`ifdef AES_TX_GAP_EN
        S_GAP: begin
          tx_q <= '0;
          if (gap_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
`endif
        default: begin
          tx_q    <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign aes_tx = tx_q;

endmodule

// File: tb/tb_aes_byte_tx.sv
// tb_aes_byte_tx: directed sequence with randomized key/text for aes_byte_tx.
// The bench builds the expected byte stream from the frame definition: 32
// bytes, each held for DIV cycles, with the strobe high in the first half.
// It then compares that stream cycle by cycle, sampling on the falling edge.
module tb_aes_byte_tx;

  localparam int CLK_FREQ    = 8;
  localparam int AES_TX_FREQ = 2;
  localparam int GAP_BYTES   = 4;
  localparam int DIV         = CLK_FREQ / AES_TX_FREQ;
  localparam int FRAME_CYC   = 32 * DIV;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic [127:0] text;
  logic         busy;
  logic         done;
  logic [8:0]   aes_tx;

  int n_vec;
  int n_err;
  logic [8:0] exp_q[$];

  aes_byte_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .AES_TX_FREQ(AES_TX_FREQ),
    .GAP_BYTES  (GAP_BYTES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .key   (key),
    .text  (text),
    .busy  (busy),
    .done  (done),
    .aes_tx(aes_tx)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"},   aes_tx,         9'h000);
    chk({tag, "_busy"}, {8'h00, busy},  9'h000);
    chk({tag, "_done"}, {8'h00, done},  9'h000);
  endtask

  // Reference model: the full per-cycle stream of one frame
  task automatic build_exp(input logic [127:0] k_in, input logic [127:0] t_in);
    logic [255:0] frame;
    logic [7:0]   b;
    frame = {k_in, t_in};
    exp_q = {};
    for (int n = 0; n < 32; n++) begin
      b = frame[255 - 8*n -: 8];
      for (int d = 0; d < DIV; d++) begin
        exp_q.push_back({(d < DIV / 2) ? 1'b1 : 1'b0, b});
      end
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one frame and check every cycle through to the first idle cycle.
  // iso_c: cycle at which inputs are scrambled and start pulsed (0 = never).
  // hold: keep start high throughout.
  task automatic send_frame(input logic [127:0] k_in, input logic [127:0] t_in,
                            input int iso_c, input bit hold);
    int dones;
    build_exp(k_in, t_in);
    key   = k_in;
    text  = t_in;
    start = 1'b1;
    dones = 0;
    for (int c = 1; c <= FRAME_CYC; c++) begin
      @(negedge clk);
      if (!hold) start = (c == iso_c);
      if (c == iso_c) begin
        key  = rnd128();
        text = rnd128();
      end
      chk("frame_tx",   aes_tx,        exp_q.pop_front());
      chk("frame_busy", {8'h00, busy}, 9'h001);
      chk("frame_done", {8'h00, done}, (c == FRAME_CYC) ? 9'h001 : 9'h000);
      if (done) dones++;
    end
`ifdef AES_TX_GAP_EN
    for (int g = 1; g <= GAP_BYTES * DIV; g++) begin
      @(negedge clk);
      if (!hold) start = (g == 2);
      chk("gap_tx",   aes_tx,        9'h000);
      chk("gap_busy", {8'h00, busy}, 9'h001);
      chk("gap_done", {8'h00, done}, 9'h000);
    end
`endif
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk_idle("post_frame");
    chk("done_count", 9'(dones), 9'h001);
  endtask

  // Directed sequence
  initial begin
    logic [127:0] k_fix;
    logic [127:0] t_fix;
    logic [127:0] k_r;
    logic [127:0] t_r;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    key   = '0;
    text  = '0;
    k_fix = 128'h000102030405060708090a0b0c0d0e0f;
    t_fix = 128'h00112233445566778899aabbccddeeff;

    // Reset and idle
    repeat (3) begin
      @(negedge clk);
      chk_idle("in_reset");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_idle("idle");
    end

    // Single frame with the reference vectors
    send_frame(k_fix, t_fix, 0, 1'b0);
    repeat (2) @(negedge clk);

    // Input isolation: scramble inputs and pulse start during byte 5
    send_frame(k_fix, t_fix, 5 * DIV + 2, 1'b0);
    repeat (3) @(negedge clk);

    // Back-to-back with start held high
    k_r = rnd128();
    t_r = rnd128();
    send_frame(k_r, t_r, 0, 1'b1);
    send_frame(rnd128(), rnd128(), 0, 1'b0);

    // Random frames
    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      send_frame(rnd128(), rnd128(), 0, 1'b0);
    end

    // Reset in the middle of byte 10
    k_r = rnd128();
    t_r = rnd128();
    build_exp(k_r, t_r);
    key   = k_r;
    text  = t_r;
    start = 1'b1;
    for (int c = 1; c <= 10 * DIV + 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("pre_reset_tx", aes_tx, exp_q.pop_front());
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    repeat (3) begin
      @(negedge clk);
      chk_idle("held_reset");
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_idle("after_reset");
    end
    send_frame(rnd128(), rnd128(), 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
